// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding memory request, a one-entry hold
// buffer for words that arrive while decode is stalled, and redirect squashing.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] hold_q, hold_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        load_rsp_s;
    logic        load_hold_s;
    logic [31:0] redir_pc_s;

    assign redir_pc_s     = redirect_pc & 32'hFFFF_FFFC;
    // A reset cycle never issues, so the abandoned request is not followed by a new one.
    assign imem_req_valid = (state_q == ST_REQ) & ~redirect_valid & ~rst;
    assign imem_req_addr  = pc_q;
    assign id_valid       = id_valid_q;
    assign id_instr       = id_instr_q;
    assign id_pc          = id_pc_q;
    assign id_pc_plus4    = id_pc_plus4_q;

    // Fetch FSM next-state, pc and hold-buffer logic.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        hold_d      = hold_q;
        load_rsp_s  = 1'b0;
        load_hold_s = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = redir_pc_s;
                end else if (imem_req_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc_s;
                    state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
                end else if (imem_rsp_valid) begin
                    if (!id_valid_q || !stall) begin
                        load_rsp_s = 1'b1;
                        state_d    = ST_REQ;
                    end else begin
                        hold_d  = imem_rsp_data;
                        state_d = ST_HOLD;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc_s;
                    hold_d  = 32'd0;
                    state_d = ST_REQ;
                end else if (!stall) begin
                    load_hold_s = 1'b1;
                    state_d     = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (redirect_valid) begin
                    pc_d = redir_pc_s;
                end else begin
                    pc_d = pc_q;
                end
                state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // Decode-side register next values; redirect wins over stall and new loads.
    always_comb begin
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        if (redirect_valid) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (load_rsp_s) begin
            id_valid_d    = 1'b1;
            id_instr_d    = imem_rsp_data;
            id_pc_d       = req_pc_q;
            id_pc_plus4_d = req_pc_q + 32'd4;
        end else if (load_hold_s) begin
            id_valid_d    = 1'b1;
            id_instr_d    = hold_q;
            id_pc_d       = req_pc_q;
            id_pc_plus4_d = req_pc_q + 32'd4;
        end else if (id_valid_q && !stall) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else begin
            id_valid_d = id_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_REQ;
            pc_q          <= RESET_PC;
            req_pc_q      <= 32'd0;
            hold_q        <= 32'd0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd4;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            hold_q        <= hold_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
        end
    end

endmodule
